// File: rtl/taint_src_feeder_if.sv
// Valid/ready pair channel carrying one (x1, x2) sample pair per transfer.
// master drives valid/x1/x2 and samples ready; slave does the reverse.
interface taint_src_feeder_if #(
    parameter int unsigned W = 1
);
    logic         valid;
    logic         ready;
    logic [W-1:0] x1;
    logic [W-1:0] x2;

    modport master (output valid, output x1, output x2, input ready);
    modport slave  (input valid, input x1, input x2, output ready);
endinterface

// File: rtl/taint_src_feeder.sv
// Registered FIFO feeding (x1, x2) taint-source pairs downstream; no combinational in->out path.
// Optional macro TAINT_SRC_FEEDER_HOLD_LAST_EN: x1/x2 show the last popped pair while empty.
module taint_src_feeder #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    taint_src_feeder_if.slave      in_if,
    taint_src_feeder_if.master     out_if,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*W-1:0] mem_q [DEPTH];
    logic [2*W-1:0] mem_d [DEPTH];
    logic           ovf_q, ovf_d;
    logic           stall_q, stall_d;
    logic [W-1:0]   prev_x1_q, prev_x1_d;
    logic [W-1:0]   prev_x2_q, prev_x2_d;
    logic [2*W-1:0] head;
    logic [2*W-1:0] idle_pair;
    logic           push, pop;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign in_if.ready  = !full;
    assign out_if.valid = !empty;
    assign ovf_err      = ovf_q;
    assign push         = in_if.valid & !full;
    assign pop          = !empty & out_if.ready;
    assign head         = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {in_if.x1, in_if.x2};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // A stalled offer must reappear unchanged next cycle; any drop or edit is sticky.
    always_comb begin
        stall_d   = in_if.valid & !full;
        stall_d   = in_if.valid & full;
        prev_x1_d = in_if.x1;
        prev_x2_d = in_if.x2;
        ovf_d     = ovf_q;
        if (stall_q && (!in_if.valid || in_if.x1 != prev_x1_q || in_if.x2 != prev_x2_q)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            stall_q   <= 1'b0;
            prev_x1_q <= '0;
            prev_x2_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            stall_q   <= stall_d;
            prev_x1_q <= prev_x1_d;
            prev_x2_q <= prev_x2_d;
        end
    end

    // Storage needs no reset: it is masked from the outputs whenever empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef TAINT_SRC_FEEDER_HOLD_LAST_EN
    logic [2*W-1:0] last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (flush) begin
            last_d = '0;
        end else if (pop) begin
            last_d = head;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign idle_pair = last_q;
`else
    assign idle_pair = '0;
`endif

    always_comb begin
        out_if.x1 = idle_pair[2*W-1:W];
        out_if.x2 = idle_pair[W-1:0];
        if (!empty) begin
            out_if.x1 = head[2*W-1:W];
            out_if.x2 = head[W-1:0];
        end
    end
endmodule

// File: tb/tb_taint_src_feeder.sv
// Randomized and directed bench for taint_src_feeder against a queue-based reference model.
module tb_taint_src_feeder;
    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic full, empty, ovf_err;

    taint_src_feeder_if #(.W(W)) in_if ();
    taint_src_feeder_if #(.W(W)) out_if ();

    taint_src_feeder #(.W(W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .in_if   (in_if),
        .out_if  (out_if),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference state: a plain queue of pairs plus the protocol-watch memory.
    logic [2*W-1:0] mq[$];
    logic [2*W-1:0] m_last;
    logic           m_ovf;
    logic           m_prev_stall;
    logic [W-1:0]   m_prev_a, m_prev_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [2*W-1:0] p;
`ifdef TAINT_SRC_FEEDER_HOLD_LAST_EN
        p = m_last;
`else
        p = '0;
`endif
        if (mq.size() > 0) p = mq[0];
        chk("out_valid", 32'(out_if.valid), 32'(mq.size() > 0));
        chk("x1",        32'(out_if.x1),    32'(p[2*W-1:W]));
        chk("x2",        32'(out_if.x2),    32'(p[W-1:0]));
        chk("in_ready",  32'(in_if.ready),  32'(mq.size() < DEPTH));
        chk("full",      32'(full),         32'(mq.size() == DEPTH));
        chk("empty",     32'(empty),        32'(mq.size() == 0));
        chk("ovf_err",   32'(ovf_err),      32'(m_ovf));
    endtask

    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy, input logic fl, input logic rn);
        logic rdy;
        in_if.valid  = v;
        in_if.x1     = a;
        in_if.x2     = b;
        out_if.ready = ordy;
        flush        = fl;
        rst_n        = rn;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            m_last       = '0;
            m_ovf        = 1'b0;
            m_prev_stall = 1'b0;
            m_prev_a     = '0;
            m_prev_b     = '0;
        end else begin
            if (m_prev_stall && (!v || a != m_prev_a || b != m_prev_b)) m_ovf = 1'b1;
            rdy = (mq.size() < DEPTH);
            if (fl) begin
                mq.delete();
                m_last = '0;
            end else begin
                if (ordy && mq.size() > 0) m_last = mq.pop_front();
                if (v && rdy) mq.push_back({a, b});
            end
            m_prev_stall = v && !rdy;
            m_prev_a     = a;
            m_prev_b     = b;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic           v, ordy, fl, rn;
        logic [W-1:0]   a, b;
        mq.delete();
        m_last = '0;
        m_ovf = 1'b0;
        m_prev_stall = 1'b0;
        m_prev_a = '0;
        m_prev_b = '0;
        @(negedge clk);

        // 1: reset, single push visible one cycle later
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_x1", 32'(out_if.x1), 32'd0);
        chk("rst_in_ready", 32'(in_if.ready), 32'd1);
        step(1, 1, 0, 0, 0, 1);
        chk("t1_x1", 32'(out_if.x1), 32'd1);
        chk("t1_valid", 32'(out_if.valid), 32'd1);
        step(0, 0, 0, 1, 0, 1);

        // 2: fill, hold E at full, drain in order; E enters after first pop
        step(1, 4'hA, 4'h1, 0, 0, 1);
        step(1, 4'hB, 4'h2, 0, 0, 1);
        step(1, 4'hC, 4'h3, 0, 0, 1);
        step(1, 4'hD, 4'h4, 0, 0, 1);
        chk("t2_full", 32'(full), 32'd1);
        step(1, 4'hE, 4'h5, 0, 0, 1);
        step(1, 4'hE, 4'h5, 1, 0, 1);
        chk("t2_x1_B", 32'(out_if.x1), 32'hB);
        step(1, 4'hE, 4'h5, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 1);
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: steady count of two across pointer wrap
        step(1, 4'h1, 4'h9, 0, 0, 1);
        step(1, 4'h2, 4'h8, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 4'(i + 3), 4'(15 - i), 1, 0, 1);
        chk("t3_ovf", 32'(ovf_err), 32'd0);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        // 4: flush wins over simultaneous push and pop
        for (int i = 0; i < 3; i++) step(1, 4'(i + 6), 4'(i), 0, 0, 1);
        step(1, 4'hF, 4'hF, 1, 1, 1);
        chk("t4_empty", 32'(empty), 32'd1);
        step(0, 0, 0, 0, 0, 1);

        // 5: alter a stalled offer, flag survives flush, cleared by reset
        for (int i = 0; i < 4; i++) step(1, 4'(i), 4'(i), 0, 0, 1);
        step(1, 4'h7, 4'h7, 0, 0, 1);
        step(1, 4'h6, 4'h7, 0, 0, 1);
        chk("t5_ovf", 32'(ovf_err), 32'd1);
        step(0, 0, 0, 0, 1, 1);
        chk("t5_ovf_flush", 32'(ovf_err), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("t5_ovf_rst", 32'(ovf_err), 32'd0);

        // 6: idle output after popping (1,1)
        step(1, 1, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
`ifdef TAINT_SRC_FEEDER_HOLD_LAST_EN
        chk("t6_x1_hold", 32'(out_if.x1), 32'd1);
`else
        chk("t6_x1_zero", 32'(out_if.x1), 32'd0);
`endif

        // Random traffic with a mostly well-behaved producer
        v = 0; a = 0; b = 0;
        for (int i = 0; i < 800; i++) begin
            rn = ($urandom_range(0, 149) != 0);
            fl = ($urandom_range(0, 29) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            if (!(m_prev_stall && $urandom_range(0, 59) != 0)) begin
                v = ($urandom_range(0, 3) != 0);
                a = W'($urandom);
                b = W'($urandom);
            end
            step(v, a, b, ordy, fl, rn);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/taint_src_feeder.md
Name: taint_src_feeder

Overview:
- Upstream stage that feeds the taint-tracked `top` hierarchy.
- Accepts (x1, x2) sample pairs from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Presents the head pair on `x1`/`x2` with `out_valid` for the downstream consumer.
- `x1`/`x2` are the intended taint sources downstream, so every path from `in_x1`/`in_x2` to `x1`/`x2` goes through clocked storage; there is no combinational bypass.

Parameters:
- W, 1, width of each lane (x1 and x2 are each W bits).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- flush  input  1  synchronous clear of FIFO contents (active-high).
- in_valid  input  1  producer has a pair on in_x1/in_x2.
- in_ready  output  1  feeder accepts a pair this cycle.
- in_x1  input  W  lane-1 data.
- in_x2  input  W  lane-2 data.
- out_valid  output  1  x1/x2 hold a valid head pair.
- out_ready  input  1  consumer takes the head pair this cycle.
- x1  output  W  head lane-1 data, to downstream x1.
- x2  output  W  head lane-2 data, to downstream x2.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf_err  output  1  sticky protocol-error flag.

Behaviour:
- State:
  - wr_ptr, rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - Storage is DEPTH x 2W bits, plus the ovf_err register.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = !full, combinational from count only. It does not depend on out_ready: no push into a full FIFO even when a pop occurs in the same cycle.
- out_valid = !empty.
- x1/x2 = storage[rd_ptr] (first-word fall-through, read from registers).
- When empty, x1/x2 = 0 (see Optional Feature).
- Latency: a pair pushed in cycle N is visible on x1/x2 with out_valid=1 in cycle N+1, earliest. There is no same-cycle bypass, including when the FIFO is empty.
- Per-cycle update, in priority order:
  1. !rst_n: wr_ptr=rd_ptr=count=0, ovf_err=0. Storage contents are don't-care but must not reach outputs while empty.
  2. flush: wr_ptr=rd_ptr=count=0. Any push or pop in that cycle is discarded. ovf_err is unchanged.
  3. Otherwise:
     - push writes storage[wr_ptr] and increments wr_ptr.
     - pop increments rd_ptr.
     - count += push - pop.
     - Simultaneous push and pop when 0<count<DEPTH leaves count unchanged; both pointers advance.
- Boundary cases:
  - Empty with out_ready=1: no pop; pointers and count unchanged.
  - Full with in_valid=1: no push; the producer must hold its data.
  - Pointer wrap from DEPTH-1 to 0 is seamless; order is strictly FIFO.
- ovf_err sets when in_valid was 1 in cycle N with in_ready=0, and in_x1/in_x2 or in_valid changed in cycle N+1 (producer dropped or altered a stalled pair). It clears only on reset.
- Reset mid-operation: reset takes effect at the next posedge; all queued pairs are lost. In the following cycle out_valid=0, in_ready=1, full=0, empty=1.
- Outputs after reset: in_ready=1, out_valid=0, x1=0, x2=0, full=0, empty=1, ovf_err=0.

Optional Feature:
- Macro: TAINT_SRC_FEEDER_HOLD_LAST_EN.
- Defined:
  - Adds a 2W-bit last-popped register, reset to 0.
  - Loaded with the head pair on every pop; cleared by flush.
  - When empty, x1/x2 drive this register instead of 0.
  - out_valid semantics are unchanged.
- Undefined: x1/x2 = 0 whenever empty; no extra register.

Test Plan:
1. Reset, then push (in_x1=1, in_x2=0) at cycle 1 with out_ready=0 -> cycle 2: out_valid=1, x1=1, x2=0, count=1, empty=0.
2. Push 4 pairs A,B,C,D back-to-back with out_ready=0 -> full=1, in_ready=0 after the 4th. Assert in_valid with E held -> not accepted. Then out_ready=1 for 4 cycles -> outputs A,B,C,D in order, then empty=1. E accepted the cycle after the first pop.
3. Keep the FIFO at count=2 with push and pop every cycle for 10 cycles -> count stays 2, ordering preserved across pointer wrap, ovf_err=0.
4. Fill 3 entries, assert flush with in_valid=1 and out_ready=1 in the same cycle -> next cycle: empty=1, out_valid=0, x1=x2=0, nothing written.
5. Stall at full, then change in_x1 while in_valid=1 and in_ready=0 -> ovf_err=1 next cycle. ovf_err stays 1 through flush; it clears only after rst_n=0 for one cycle.
6. With TAINT_SRC_FEEDER_HOLD_LAST_EN: push (1,1), pop it -> while empty, x1=1, x2=1, out_valid=0. Without the macro, the same stimulus gives x1=x2=0.
